// File: rtl/bridge_pkg.sv
// Shared types and constants for the bridge bus initiator and its bus interface.
package bridge_pkg;

  localparam int unsigned BRIDGE_ADDR_W      = 32;
  localparam int unsigned BRIDGE_DATA_W      = 32;
  localparam int unsigned BRIDGE_WORD_STRIDE = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_DATA,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_FINISH
  } bridge_init_state_e;

  // One bus beat as driven onto the segment (address phase plus write data).
  typedef struct packed {
    logic [BRIDGE_ADDR_W-1:0] addr;
    logic [BRIDGE_DATA_W-1:0] data;
  } bridge_beat_t;

  function automatic logic [BRIDGE_ADDR_W-1:0] word_align(input logic [BRIDGE_ADDR_W-1:0] a);
    return a & ~BRIDGE_ADDR_W'(3);
  endfunction

endpackage

// File: rtl/bus_if.sv
// Bridge bus segment: one master drives address/strobes, responders return read data.
interface bus_if;
  import bridge_pkg::*;

  logic                     clk;
  logic [BRIDGE_ADDR_W-1:0] addr;
  logic                     wr;
  logic [BRIDGE_DATA_W-1:0] wr_data;
  logic                     rd;
  logic [BRIDGE_DATA_W-1:0] rd_data;
  logic                     rd_data_valid;

  modport master (
    output clk, addr, wr, wr_data, rd,
    input  rd_data, rd_data_valid
  );

  modport responder (
    input  clk, addr, wr, wr_data, rd,
    output rd_data, rd_data_valid
  );

endinterface

// File: rtl/bridge_initiator.sv
// Bus master for one bridge segment: runs single/burst reads and writes from a command
// stream, one outstanding read at a time with a response timeout.
module bridge_initiator
  import bridge_pkg::*;
#(
  parameter int unsigned LEN_W   = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [BRIDGE_ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]         cmd_len,
  input  logic                     wdata_valid,
  output logic                     wdata_ready,
  input  logic [BRIDGE_DATA_W-1:0] wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [BRIDGE_DATA_W-1:0] rsp_data,
  output logic                     done,
  output logic                     error,
  bus_if.master                    bridge
);

  localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0]         TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [BRIDGE_ADDR_W-1:0] STRIDE   = BRIDGE_ADDR_W'(BRIDGE_WORD_STRIDE);
  localparam logic [LEN_W-1:0]         LEN_ONE  = LEN_W'(1);

  bridge_init_state_e state_q, state_d;

  logic [BRIDGE_ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]         count_q, count_d;
  logic [TMR_W-1:0]         timer_q, timer_d;
  logic                     err_q, err_d;
  bridge_beat_t             beat_q, beat_d;
  logic                     wr_q, wr_d;
  logic                     rd_q, rd_d;
  logic                     rsp_valid_q, rsp_valid_d;
  logic [BRIDGE_DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic                     done_q, done_d;
  logic                     error_q, error_d;
  logic                     cmd_ready_q, cmd_ready_d;
  logic                     wdata_ready_q, wdata_ready_d;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and next values of every registered output / datapath register
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    count_d     = count_q;
    timer_d     = timer_q;
    err_d       = err_q;
    beat_d      = beat_q;
    wr_d        = 1'b0;
    rd_d        = 1'b0;
    rsp_valid_d = rsp_valid_q & ~rsp_ready;
    rsp_data_d  = rsp_data_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          addr_d  = word_align(cmd_addr);
          count_d = cmd_len;
          err_d   = 1'b0;
          if (cmd_len == '0) begin
            state_d = ST_FINISH;
          end else if (cmd_write) begin
            state_d = ST_WR_DATA;
          end else begin
            state_d = ST_RD_ISSUE;
          end
        end
      end

      ST_WR_DATA: begin
        if (wdata_valid && wdata_ready_q) begin
          wr_d        = 1'b1;
          beat_d.addr = addr_q;
          beat_d.data = wdata;
          addr_d      = addr_q + STRIDE;
          count_d     = count_q - LEN_ONE;
          if (count_q == LEN_ONE) begin
            state_d = ST_FINISH;
          end
        end
      end

      // The output slot counts as free if it is being consumed on this same edge.
      ST_RD_ISSUE: begin
        if (!rsp_valid_d) begin
          rd_d        = 1'b1;
          beat_d.addr = addr_q;
          timer_d     = '0;
          state_d     = ST_RD_WAIT;
        end
      end

      ST_RD_WAIT: begin
        if (bridge.rd_data_valid) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = bridge.rd_data;
          addr_d      = addr_q + STRIDE;
          count_d     = count_q - LEN_ONE;
          state_d     = (count_q == LEN_ONE) ? ST_FINISH : ST_RD_ISSUE;
        end else if (timer_q == TMR_LAST) begin
          err_d   = 1'b1;
          state_d = ST_FINISH;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      ST_FINISH: begin
        if (!rsp_valid_q) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // done marks the final FINISH cycle, which is always one with the output slot empty.
    done_d        = (state_d == ST_FINISH) && !rsp_valid_d;
    error_d       = done_d && err_d;
    cmd_ready_d   = (state_d == ST_IDLE);
    wdata_ready_d = (state_d == ST_WR_DATA);
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q        <= '0;
      count_q       <= '0;
      timer_q       <= '0;
      err_q         <= 1'b0;
      beat_q        <= '0;
      wr_q          <= 1'b0;
      rd_q          <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      cmd_ready_q   <= 1'b1;
      wdata_ready_q <= 1'b0;
    end else begin
      addr_q        <= addr_d;
      count_q       <= count_d;
      timer_q       <= timer_d;
      err_q         <= err_d;
      beat_q        <= beat_d;
      wr_q          <= wr_d;
      rd_q          <= rd_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      done_q        <= done_d;
      error_q       <= error_d;
      cmd_ready_q   <= cmd_ready_d;
      wdata_ready_q <= wdata_ready_d;
    end
  end

  assign bridge.clk     = clk;
  assign bridge.addr    = beat_q.addr;
  assign bridge.wr_data = beat_q.data;
  assign bridge.wr      = wr_q;
  assign bridge.rd      = rd_q;

  assign cmd_ready   = cmd_ready_q;
  assign wdata_ready = wdata_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign done        = done_q;
  assign error       = error_q;

endmodule

// File: tb/tb_bridge_initiator.sv
// Scoreboard bench for bridge_initiator with a registered responder returning addr^0xA5A5_0000.
module tb_bridge_initiator;
  import bridge_pkg::*;

  localparam int unsigned LEN_W   = 8;
  localparam int unsigned TIMEOUT = 16;
  localparam logic [31:0] PATTERN = 32'hA5A5_0000;

  logic             clk;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_write;
  logic [31:0]      cmd_addr;
  logic [LEN_W-1:0] cmd_len;
  logic             wdata_valid;
  logic             wdata_ready;
  logic [31:0]      wdata;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_data;
  logic             done;
  logic             error;

  bus_if bus ();

  bridge_initiator #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .done(done), .error(error), .bridge(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int rsp_seen = 0;
  int done_seen = 0;
  int rd_cyc = 0;
  int rd_gap = 0;
  int done_cyc = 0;
  bit prev_rd = 1'b0;
  bit silent = 1'b0;

  logic [31:0]  exp_rsp[$];
  logic [31:0]  exp_rd[$];
  bridge_beat_t exp_wr[$];
  bit           exp_err[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  task automatic fail_evt(input string name);
    checks++;
    errors++;
    $display("FAIL %s unexpected event or wait bound expired", name);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Responder: answers every rd one cycle later unless silenced
  always @(posedge clk) begin
    if (reset) begin
      bus.rd_data_valid <= 1'b0;
      bus.rd_data       <= '0;
    end else begin
      bus.rd_data_valid <= bus.rd && !silent;
      bus.rd_data       <= bus.addr ^ PATTERN;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents something
  always @(negedge clk) begin
    if (reset) begin
      prev_rd = 1'b0;
    end else begin
      if (bus.rd) begin
        if (exp_rd.size() == 0) fail_evt("rd_unexpected");
        else chk("rd_addr", bus.addr, exp_rd.pop_front());
        chk("rd_one_cycle", 32'(prev_rd), 32'd0);
        chk("rd_with_rsp_pending", 32'(rsp_valid), 32'd0);
        chk("rd_wr_exclusive", 32'(bus.wr), 32'd0);
        rd_gap = cyc - rd_cyc;
        rd_cyc = cyc;
        rd_cnt++;
      end
      prev_rd = bus.rd;
      if (bus.wr) begin
        if (exp_wr.size() == 0) fail_evt("wr_unexpected");
        else begin
          bridge_beat_t b;
          b = exp_wr.pop_front();
          chk("wr_addr", bus.addr, b.addr);
          chk("wr_data", bus.wr_data, b.data);
        end
        wr_cnt++;
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_rsp.size() == 0) fail_evt("rsp_unexpected");
        else chk("rsp_data", rsp_data, exp_rsp.pop_front());
        rsp_seen++;
      end
      if (done) begin
        if (exp_err.size() == 0) fail_evt("done_unexpected");
        else chk("done_error", 32'(error), 32'(exp_err.pop_front()));
        chk("done_after_all_data", 32'(exp_rsp.size()), 32'd0);
        done_seen++;
        done_cyc = cyc;
      end else begin
        chk("error_without_done", 32'(error), 32'd0);
      end
    end
  end

  task automatic send_cmd(input bit w, input logic [31:0] a, input logic [LEN_W-1:0] n);
    int k = 0;
    @(negedge clk);
    while (!cmd_ready && k < 100) begin @(negedge clk); k++; end
    if (!cmd_ready) fail_evt("cmd_ready_wait");
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_len   = n;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d);
    int k = 0;
    wdata_valid = 1'b1;
    wdata       = d;
    @(negedge clk);
    while (!wdata_ready && k < 100) begin @(negedge clk); k++; end
    if (!wdata_ready) fail_evt("wdata_ready_wait");
    @(posedge clk);
    #1 wdata_valid = 1'b0;
  endtask

  task automatic wait_count(input string name, input int which, input int start);
    int k = 0;
    int cur;
    cur = (which == 0) ? done_seen : (which == 1) ? rd_cnt : rsp_seen;
    while (cur <= start && k < 300) begin
      @(negedge clk);
      #1;
      k++;
      cur = (which == 0) ? done_seen : (which == 1) ? rd_cnt : rsp_seen;
    end
    if (cur <= start) fail_evt(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, w0, d0, s0;
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wdata_valid = 1'b0; wdata = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_wdata_ready", 32'(wdata_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rd_wr", {30'd0, bus.rd, bus.wr}, 32'd0);
    chk("rst_addr", bus.addr, 32'd0);
    chk("rst_wr_data", bus.wr_data, 32'd0);

    // 1: read burst of three from 0x0
    r0 = rd_cnt; w0 = wr_cnt; d0 = done_seen;
    exp_rd.push_back(32'h0); exp_rd.push_back(32'h4); exp_rd.push_back(32'h8);
    exp_rsp.push_back(32'hA5A5_0000); exp_rsp.push_back(32'hA5A5_0004);
    exp_rsp.push_back(32'hA5A5_0008);
    exp_err.push_back(1'b0);
    send_cmd(1'b0, 32'h0, 8'd3);
    wait_count("t1_done", 0, d0);
    chk("t1_rd_count", 32'(rd_cnt - r0), 32'd3);
    chk("t1_wr_count", 32'(wr_cnt - w0), 32'd0);

    // 2: write burst of two to 0x10
    r0 = rd_cnt; w0 = wr_cnt; d0 = done_seen;
    exp_wr.push_back('{addr: 32'h10, data: 32'h1111_1111});
    exp_wr.push_back('{addr: 32'h14, data: 32'h2222_2222});
    exp_err.push_back(1'b0);
    send_cmd(1'b1, 32'h10, 8'd2);
    send_word(32'h1111_1111);
    send_word(32'h2222_2222);
    wait_count("t2_done", 0, d0);
    chk("t2_wr_count", 32'(wr_cnt - w0), 32'd2);
    chk("t2_rd_count", 32'(rd_cnt - r0), 32'd0);

    // 3: read four from 0x40 while the consumer stalls after the first word
    r0 = rd_cnt; d0 = done_seen; s0 = rsp_seen;
    for (int i = 0; i < 4; i++) begin
      exp_rd.push_back(32'h40 + 32'(4 * i));
      exp_rsp.push_back((32'h40 + 32'(4 * i)) ^ PATTERN);
    end
    exp_err.push_back(1'b0);
    send_cmd(1'b0, 32'h41, 8'd4);
    wait_count("t3_first_word", 2, s0);
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    repeat (10) @(posedge clk);
    chk("t3_rd_held", 32'(rd_cnt - r0), 32'd2);
    #1 rsp_ready = 1'b1;
    wait_count("t3_done", 0, d0);
    chk("t3_rsp_count", 32'(rsp_seen - s0), 32'd4);
    chk("t3_rd_count", 32'(rd_cnt - r0), 32'd4);

    // 4: silent responder at 0x20 -> timeout error
    d0 = done_seen; s0 = rsp_seen;
    silent = 1'b1;
    exp_rd.push_back(32'h20);
    exp_err.push_back(1'b1);
    send_cmd(1'b0, 32'h20, 8'd1);
    wait_count("t4_done", 0, d0);
    chk("t4_timeout_latency", 32'(done_cyc - rd_cyc), 32'd16);
    chk("t4_no_rsp", 32'(rsp_seen - s0), 32'd0);
    silent = 1'b0;

    // 5a: zero-length command
    r0 = rd_cnt; w0 = wr_cnt; d0 = done_seen;
    exp_err.push_back(1'b0);
    send_cmd(1'b0, 32'h100, 8'd0);
    wait_count("t5a_done", 0, d0);
    chk("t5a_latency_le2", 32'(done_cyc - cyc <= 2), 32'd1);
    chk("t5a_no_bus", 32'((rd_cnt - r0) + (wr_cnt - w0)), 32'd0);

    // 5b: address wrap at top of space
    d0 = done_seen;
    exp_rd.push_back(32'hFFFF_FFFC); exp_rd.push_back(32'h0);
    exp_rsp.push_back(32'h5A5A_FFFC); exp_rsp.push_back(32'hA5A5_0000);
    exp_err.push_back(1'b0);
    send_cmd(1'b0, 32'hFFFF_FFFC, 8'd2);
    wait_count("t5b_done", 0, d0);
    chk("t5b_rd_spacing", 32'(rd_gap), 32'd3);

    // 6: reset while waiting for read data
    r0 = rd_cnt; d0 = done_seen;
    silent = 1'b1;
    exp_rd.push_back(32'h200);
    send_cmd(1'b0, 32'h200, 8'd2);
    wait_count("t6_rd", 1, r0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_rd_wr_after_reset", {30'd0, bus.rd, bus.wr}, 32'd0);
    chk("t6_rsp_valid_after_reset", 32'(rsp_valid), 32'd0);
    chk("t6_done_after_reset", 32'(done), 32'd0);
    reset = 1'b0;
    silent = 1'b0;
    @(posedge clk);
    #1 chk("t6_cmd_ready", 32'(cmd_ready), 32'd1);
    repeat (20) @(posedge clk);
    chk("t6_no_done", 32'(done_seen - d0), 32'd0);

    // 7: normal operation after the aborted command
    d0 = done_seen;
    exp_rd.push_back(32'h4);
    exp_rsp.push_back(32'hA5A5_0004);
    exp_err.push_back(1'b0);
    send_cmd(1'b0, 32'h4, 8'd1);
    wait_count("t7_done", 0, d0);
    repeat (3) @(posedge clk);
    chk("end_queues_empty", 32'(exp_rsp.size() + exp_rd.size() + exp_wr.size() + exp_err.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
